// File: rtl/sd_dac_seq_if.sv
// rtl/sd_dac_seq_if.sv - sample handshake bundle for sd_dac_seq
//
// Purpose: carries 4-bit sample codes from an upstream producer into the
//          modulator's one-entry sample buffer.
// Signals:
//    s_valid  producer has a sample on s_data
//    s_ready  modulator buffer can accept (transfer on s_valid & s_ready)
//    s_data   unsigned sample code 0..15
// Modports: master = producer side, slave = modulator side.

interface sd_dac_seq_if;
   logic       s_valid;
   logic       s_ready;
   logic [3:0] s_data;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );
endinterface

// File: rtl/sd_dac_seq.sv
// rtl/sd_dac_seq.sv - first-order 1-bit sigma-delta DAC sequencer
//
// Purpose: takes 4-bit samples through a one-entry buffer and turns each
//          into a 2**OSR_LOG2-cycle stretch of 1-bit sigma-delta output.
//          The accumulator carry-out is the DAC bit.
// Parameters:
//    OSR_LOG2     log2 of clk cycles per sample period (1..8)
// Ports:
//    clk          rising-edge clock
//    rst          asynchronous active-high reset
//    en           modulator enable (level)
//    underrun_clr synchronous clear of the underrun flag
//    smp          sample handshake (slave modport of sd_dac_seq_if)
//    dac_out      registered 1-bit stream
//    sample_tick  one-cycle pulse at the start of each sample period
//    underrun     sticky: a period boundary found no new sample
// Build option:
//    SD_DAC_SEQ_DITHER_EN  adds a 4-bit LFSR whose LSB is the carry-in
//                          of the accumulator while running.

module sd_dac_seq #(
   parameter int OSR_LOG2 = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            underrun_clr,
   sd_dac_seq_if.slave     smp,
   output logic            dac_out,
   output logic            sample_tick,
   output logic            underrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [OSR_LOG2-1:0] PHASE_ONE  = 1;
   localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

   state_t                state_q, state_d;
   logic [3:0]            acc_q, acc_d;
   logic [3:0]            cur_q, cur_d;
   logic [3:0]            sbuf_q, sbuf_d;
   logic                  sbuf_full_q, sbuf_full_d;
   logic [OSR_LOG2-1:0]   phase_q, phase_d;
   logic                  dac_out_q, dac_out_d;
   logic                  sample_tick_q, sample_tick_d;
   logic                  underrun_q, underrun_d;

   logic                  cin;
   logic                  xfer;
   logic                  boundary;
   logic                  underrun_set;
   logic [4:0]            sum;

`ifdef SD_DAC_SEQ_DITHER_EN
   logic [3:0]            lfsr_q, lfsr_d;
   assign cin = lfsr_q[0];
`else
   assign cin = 1'b0;
`endif

   // Ready is a pure function of the buffer flag so upstream never sees a
   // combinational path from its own valid.
   assign smp.s_ready = !sbuf_full_q;
   assign xfer        = smp.s_valid && !sbuf_full_q;
   assign boundary    = (phase_q == PHASE_LAST);
   assign sum         = {1'b0, acc_q} + {1'b0, cur_q} + {4'b0000, cin};

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      cur_d         = cur_q;
      sbuf_d        = sbuf_q;
      sbuf_full_d   = sbuf_full_q;
      phase_d       = phase_q;
      dac_out_d     = 1'b0;
      sample_tick_d = 1'b0;
      underrun_set  = 1'b0;
`ifdef SD_DAC_SEQ_DITHER_EN
      lfsr_d        = lfsr_q;
`endif

      // Normal buffer fill; the boundary bypass below overrides it.
      if (xfer) begin
         sbuf_d      = smp.s_data;
         sbuf_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            acc_d   = 4'd0;
            phase_d = '0;
            // Buffer is full here, so no transfer can coincide.
            if (en && sbuf_full_q) begin
               state_d       = RUN;
               cur_d         = sbuf_q;
               sbuf_full_d   = 1'b0;
               sample_tick_d = 1'b1;
            end
         end

         RUN: begin
            if (!en) begin
               state_d = IDLE;
               acc_d   = 4'd0;
               phase_d = '0;
            end else begin
               acc_d     = sum[3:0];
               dac_out_d = sum[4];
               phase_d   = phase_q + PHASE_ONE;
`ifdef SD_DAC_SEQ_DITHER_EN
               lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
               if (boundary) begin
                  sample_tick_d = 1'b1;
                  if (sbuf_full_q) begin
                     cur_d       = sbuf_q;
                     sbuf_full_d = 1'b0;
                  end else if (xfer) begin
                     // Sample arriving exactly at the boundary goes
                     // straight into use and never occupies the buffer.
                     cur_d       = smp.s_data;
                     sbuf_d      = sbuf_q;
                     sbuf_full_d = 1'b0;
                  end else begin
                     underrun_set = 1'b1;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (underrun_set) begin
         underrun_d = 1'b1;
      end else if (underrun_clr) begin
         underrun_d = 1'b0;
      end else begin
         underrun_d = underrun_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         acc_q         <= 4'd0;
         cur_q         <= 4'd0;
         sbuf_q        <= 4'd0;
         sbuf_full_q   <= 1'b0;
         phase_q       <= '0;
         dac_out_q     <= 1'b0;
         sample_tick_q <= 1'b0;
         underrun_q    <= 1'b0;
`ifdef SD_DAC_SEQ_DITHER_EN
         lfsr_q        <= 4'b1001;
`endif
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cur_q         <= cur_d;
         sbuf_q        <= sbuf_d;
         sbuf_full_q   <= sbuf_full_d;
         phase_q       <= phase_d;
         dac_out_q     <= dac_out_d;
         sample_tick_q <= sample_tick_d;
         underrun_q    <= underrun_d;
`ifdef SD_DAC_SEQ_DITHER_EN
         lfsr_q        <= lfsr_d;
`endif
      end
   end

   assign dac_out     = dac_out_q;
   assign sample_tick = sample_tick_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_sd_dac_seq.sv
// tb/tb_sd_dac_seq.sv - self-checking bench for sd_dac_seq (OSR_LOG2 = 4)

module tb_sd_dac_seq;

   localparam int OSR_LOG2 = 4;
   localparam int OSR      = 1 << OSR_LOG2;

   logic clk;
   logic rst;
   logic en;
   logic underrun_clr;
   logic dac_out;
   logic sample_tick;
   logic underrun;

   int checks = 0;
   int errors = 0;

   sd_dac_seq_if smp_if ();

   sd_dac_seq #(.OSR_LOG2(OSR_LOG2)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .underrun_clr (underrun_clr),
      .smp          (smp_if),
      .dac_out      (dac_out),
      .sample_tick  (sample_tick),
      .underrun     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: samples waiting in a queue, integer accumulator,
   // carry is "sum reached 16", periods counted with a modulo counter.
   int m_q[$];
   bit m_run   = 1'b0;
   int m_acc   = 0;
   int m_cur   = 0;
   int m_phase = 0;
   bit m_dac   = 1'b0;
   bit m_tick  = 1'b0;
   bit m_under = 1'b0;
   bit m_xfer;
   bit m_set;
   int m_total;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_run = 0; m_acc = 0; m_cur = 0; m_phase = 0;
         m_dac = 0; m_tick = 0; m_under = 0;
      end else begin
         m_xfer = smp_if.s_valid && (m_q.size() == 0);
         m_dac  = 0;
         m_tick = 0;
         m_set  = 0;
         if (!m_run) begin
            m_acc   = 0;
            m_phase = 0;
            if (en && m_q.size() == 1) begin
               m_cur  = m_q.pop_front();
               m_run  = 1;
               m_tick = 1;
            end else if (m_xfer) begin
               m_q.push_back(int'(smp_if.s_data));
            end
         end else if (!en) begin
            m_run   = 0;
            m_acc   = 0;
            m_phase = 0;
            if (m_xfer) m_q.push_back(int'(smp_if.s_data));
         end else begin
            m_total = m_acc + m_cur;
            m_dac   = (m_total >= 16);
            m_acc   = m_total % 16;
            if (m_phase == OSR - 1) begin
               m_tick = 1;
               if (m_q.size() > 0)  m_cur = m_q.pop_front();
               else if (m_xfer)     m_cur = int'(smp_if.s_data);
               else                 m_set = 1;
            end else if (m_xfer) begin
               m_q.push_back(int'(smp_if.s_data));
            end
            m_phase = (m_phase + 1) % OSR;
         end
         if (m_set)             m_under = 1;
         else if (underrun_clr) m_under = 0;
      end
   end

   always @(negedge clk) begin
      check("cmp_dac_out",     dac_out,        m_dac);
      check("cmp_sample_tick", sample_tick,    m_tick);
      check("cmp_underrun",    underrun,       m_under);
      check("cmp_s_ready",     smp_if.s_ready, m_q.size() == 0);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      underrun_clr = 1'b0;
      smp_if.s_valid = 1'b0;
      smp_if.s_data = 4'd0;
      #2;
      check("rst_dac_out",  dac_out,        0);
      check("rst_tick",     sample_tick,    0);
      check("rst_underrun", underrun,       0);
      check("rst_s_ready",  smp_if.s_ready, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   int ones;

   initial begin
      rst = 1'b0;
      en = 1'b0;
      underrun_clr = 1'b0;
      smp_if.s_valid = 1'b0;
      smp_if.s_data = 4'd0;
      #1;

      // Sample 8: tick right after start, then alternating 0,1,0,1
      do_reset();
      smp_if.s_valid = 1'b1; smp_if.s_data = 4'd8; en = 1'b1;
      cyc(1);
      smp_if.s_valid = 1'b0;
      check("a_ready_after_push", smp_if.s_ready, 0);
      cyc(1);
      check("a_tick_start", sample_tick, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         check("a_dac_pattern", dac_out, (i % 2));
      end
      check("a_tick_low", sample_tick, 0);

      // Samples 15 then 0: one 0 then fifteen 1s, then a silent period
      do_reset();
      smp_if.s_valid = 1'b1; smp_if.s_data = 4'd15; en = 1'b1;
      cyc(1);
      smp_if.s_data = 4'd0;
      cyc(1);
      check("b_tick_start", sample_tick, 1);
      cyc(1);
      smp_if.s_valid = 1'b0;
      check("b_first_zero", dac_out, 0);
      ones = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         ones += int'(dac_out);
      end
      check("b_ones_15", ones, 15);
      check("b_tick_period2", sample_tick, 1);
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         ones += int'(dac_out);
      end
      check("b_ones_0", ones, 0);
      check("b_tick_period3", sample_tick, 1);
      check("b_underrun_set", underrun, 1);
      underrun_clr = 1'b1;
      cyc(1);
      underrun_clr = 1'b0;
      check("b_underrun_clr", underrun, 0);

      // Sample arrives exactly on the boundary with an empty buffer
      do_reset();
      smp_if.s_valid = 1'b1; smp_if.s_data = 4'd3; en = 1'b1;
      cyc(1);
      smp_if.s_valid = 1'b0;
      cyc(16);
      smp_if.s_valid = 1'b1; smp_if.s_data = 4'd5;
      cyc(1);
      smp_if.s_valid = 1'b0;
      check("c_tick", sample_tick, 1);
      check("c_no_underrun", underrun, 0);
      check("c_buf_empty", smp_if.s_ready, 1);
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         ones += int'(dac_out);
      end
      check("c_ones_5", ones, 5);

      // en dropped at phase 7, then restarted from a full buffer
      do_reset();
      smp_if.s_valid = 1'b1; smp_if.s_data = 4'd6; en = 1'b1;
      cyc(1);
      smp_if.s_data = 4'd9;
      cyc(2);
      smp_if.s_valid = 1'b0;
      cyc(6);
      en = 1'b0;
      cyc(1);
      check("d_idle_dac", dac_out, 0);
      check("d_idle_tick", sample_tick, 0);
      check("d_buf_kept", smp_if.s_ready, 0);
      cyc(1);
      en = 1'b1;
      cyc(1);
      check("d_restart_tick", sample_tick, 1);
      check("d_restart_ready", smp_if.s_ready, 1);
      cyc(1);
      check("d_dac0", dac_out, 0);
      cyc(1);
      check("d_dac1", dac_out, 1);
      cyc(13);
      check("d_no_early_tick", sample_tick, 0);
      cyc(1);
      check("d_period_tick", sample_tick, 1);

      // Asynchronous reset while running with a full buffer
      do_reset();
      smp_if.s_valid = 1'b1; smp_if.s_data = 4'd12; en = 1'b1;
      cyc(1);
      smp_if.s_data = 4'd7;
      cyc(2);
      smp_if.s_valid = 1'b0;
      check("e_buf_full", smp_if.s_ready, 0);
      cyc(1);
      check("e_dac_before_rst", dac_out, 1);
      #1;
      rst = 1'b1;
      #1;
      check("e_async_dac", dac_out, 0);
      check("e_async_tick", sample_tick, 0);
      check("e_async_underrun", underrun, 0);
      check("e_async_ready", smp_if.s_ready, 1);
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_dac_seq.md
SD_DAC_SEQ -- requirements
Module: sd_dac_seq

Interface
REQ-001 Parameter OSR_LOG2, default 4, log2 of oversampling ratio (OSR = 2**OSR_LOG2 clk cycles per sample); legal range 1..8.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  modulator enable; level-sensitive.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  sample buffer can accept; transfer when s_valid & s_ready at a rising edge.
REQ-007 s_data  input  4  unsigned sample code, 0..15.
REQ-008 underrun_clr  input  1  synchronous clear of underrun flag.
REQ-009 dac_out  output  1  registered 1-bit sigma-delta stream (accumulator carry-out).
REQ-010 sample_tick  output  1  registered one-cycle pulse marking start of each sample period.
REQ-011 underrun  output  1  sticky: a period boundary found no new sample.

Function
REQ-012 Internal state: FSM {IDLE, RUN}; 4-bit acc; 4-bit cur (sample in use); one-entry buffer buf plus buf_full flag; OSR_LOG2-bit phase counter.
REQ-013 s_ready = !buf_full, combinational from registered state only; no dependence on s_valid.
REQ-014 Accepted transfer sets buf <= s_data, buf_full <= 1, except the boundary-bypass case in REQ-019; accepted in both states.
REQ-015 IDLE -> RUN when en=1 and buf_full=1: cur <= buf, buf_full <= 0, acc <= 0, phase <= 0, sample_tick <= 1 next cycle; no accumulation in transition cycle.
REQ-016 IDLE with en=0 or buf empty: remain IDLE; acc, phase, dac_out held at 0.
REQ-017 RUN, each cycle: {c, s} = acc + cur + cin (5-bit result, wraps mod 16), acc <= s, dac_out <= c; cin = 0 unless REQ-025 applies.
REQ-018 RUN: phase increments every cycle, wrapping OSR-1 -> 0; boundary = cycle with phase == OSR-1.
REQ-019 At boundary: if buf_full, cur <= buf and buf_full <= 0 (any transfer accepted in the same cycle is impossible since s_ready=0); else if a transfer is accepted that cycle, cur <= s_data directly and buf_full stays 0; else cur retained, underrun <= 1.
REQ-020 sample_tick = 1 in the cycle after every boundary and after REQ-015 transition; 0 otherwise.
REQ-021 RUN -> IDLE when en=0 (sampled any cycle, mid-period included): acc <= 0, phase <= 0, dac_out <= 0 next cycle; cur and buf contents retained, buf_full retained.
REQ-022 underrun_clr=1 clears underrun; if set and clear coincide, set wins.
REQ-023 Average dac_out density over one period from acc=0, no dither, equals cur/16 scaled to OSR (exactly cur*OSR/16 ones when OSR >= 16).

Reset
REQ-024 rst=1 forces immediately: state IDLE, acc 0, cur 0, buf 0, buf_full 0, phase 0, dac_out 0, sample_tick 0, underrun 0, LFSR 4'b1001; s_ready=1 after reset; reset mid-period discards sample in use.

Configuration
REQ-025 Macro SD_DAC_SEQ_DITHER_EN defined: 4-bit Fibonacci LFSR (x^4+x^3+1, seed 4'b1001) advances each RUN cycle, cin = lfsr[0]; LFSR holds in IDLE. Undefined: no LFSR, cin = 0; all other behaviour identical.

Verification
REQ-026 Reset, push 8, en=1 -> sample_tick one cycle after transition, then dac_out 0,1,0,1,... (acc 8,0,8,0).
REQ-027 Push 15 then 0, OSR_LOG2=4 -> first period dac_out 0 then fifteen 1s; second period all 0s; sample_tick each 16 cycles.
REQ-028 Push one sample only, run two periods -> underrun=1 at second boundary+1, cur unchanged; underrun_clr pulse -> 0.
REQ-029 Buffer empty, s_valid with 5 exactly at boundary -> cur=5 next cycle, buf_full stays 0, no underrun.
REQ-030 en dropped mid-period (phase 7) -> next cycle IDLE, dac_out 0, acc 0; re-enable with buf_full -> fresh period from phase 0.
REQ-031 rst asserted in RUN with buf_full=1 -> all outputs 0, s_ready=1 without a clock edge.
